serial_max_finder: RTL and testbench

// - Bit-serial MSB-first maximum search over four unsigned operands.
// - Produces a registered one-hot "winner" flag set (found_1..found_4).
// - Sits directly upstream of the 4:2 winner encoder: found_1..4 drive its input_1..input_4.
// - The one-hot guarantee lets the encoder stay a plain OR network.

---
 rtl/serial_max_finder.sv | 174 +++++++++++++++++
 tb/tb_serial_max_finder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_max_finder.sv
// serial_max_finder
// Bit-serial, MSB-first maximum search over four unsigned operands.
// The result is a registered one-hot winner flag set. It feeds a 4:2 winner
// encoder that is built as a plain OR network, so the flags must be exactly
// one-hot in every case. When two or more operands tie for the maximum, the
// lowest index wins (1 > 2 > 3 > 4).
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   start           run request; sampled only while idle
//   in_1..in_4      WIDTH-bit unsigned operands, captured on the accepted start
//   busy            high while scanning and during the done cycle
//   done            one-cycle pulse; found_* are valid from this cycle on
//   found_1..4      one-hot winner flags, held until the next accepted start
//
// Configuration
//   EARLY_EXIT_EN   when defined, the scan stops as soon as one candidate
//                   remains. Latency then depends on the data, and the
//                   result is the same as for a full scan.
module serial_max_finder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  output logic             busy,
  output logic             done,
  output logic             found_1,
  output logic             found_2,
  output logic             found_3,
  output logic             found_4
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sh1_r, sh2_r, sh3_r, sh4_r;
  logic [3:0]       mask_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       found_r;

  logic [3:0]       msb_s;
  logic [3:0]       cand_s;
  logic             any_s;
  logic [3:0]       mask_nxt_s;
  logic             finish_s;

  // Keep only the lowest-index set bit. The mask is never zero, so the
  // result is always one-hot.
  function automatic logic [3:0] pick_lowest(input logic [3:0] m);
    logic [3:0] r;
    if (m[0]) begin
      r = 4'b0001;
    end else if (m[1]) begin
      r = 4'b0010;
    end else if (m[2]) begin
      r = 4'b0100;
    end else begin
      r = 4'b1000;
    end
    return r;
  endfunction

  // True when exactly one bit of m is set.
  function automatic logic is_onehot(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'b0001)) == 4'b0000);
  endfunction

  assign msb_s = {sh4_r[WIDTH-1], sh3_r[WIDTH-1], sh2_r[WIDTH-1], sh1_r[WIDTH-1]};

  // Narrow the candidate mask for the current bit, and decide whether this is
  // the last scan cycle.
  always_comb begin
    cand_s = mask_r & msb_s;
    any_s  = |cand_s;
    // If no surviving candidate has a 1 in this bit, they all stay in the
    // running. This is what keeps the mask non-zero.
    if (any_s) begin
      mask_nxt_s = cand_s;
    end else begin
      mask_nxt_s = mask_r;
    end
`ifdef EARLY_EXIT_EN
    finish_s = (cnt_r == CNT_ZERO) || is_onehot(mask_nxt_s);
`else
    finish_s = (cnt_r == CNT_ZERO);
`endif
  end

  // Control FSM together with the datapath registers and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sh1_r   <= '0;
      sh2_r   <= '0;
      sh3_r   <= '0;
      sh4_r   <= '0;
      mask_r  <= 4'b0000;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sh1_r   <= in_1;
            sh2_r   <= in_2;
            sh3_r   <= in_3;
            sh4_r   <= in_4;
            mask_r  <= 4'b1111;
            cnt_r   <= CNT_INIT;
            found_r <= 4'b0000;
            busy_r  <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          sh1_r  <= {sh1_r[WIDTH-2:0], 1'b0};
          sh2_r  <= {sh2_r[WIDTH-2:0], 1'b0};
          sh3_r  <= {sh3_r[WIDTH-2:0], 1'b0};
          sh4_r  <= {sh4_r[WIDTH-2:0], 1'b0};
          mask_r <= mask_nxt_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (finish_s) begin
            found_r <= pick_lowest(mask_nxt_s);
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign found_1 = found_r[0];
  assign found_2 = found_r[1];
  assign found_3 = found_r[2];
  assign found_4 = found_r[3];

endmodule

// File: tb/tb_serial_max_finder.sv
// Directed bench for serial_max_finder with WIDTH=8.
// Each winner vector is written {found_1, found_2, found_3, found_4}.
// The done offset counts from the cycle in which start is sampled (T), so a
// full scan gives T+9.
module tb_serial_max_finder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in_1, in_2, in_3, in_4;
  logic             busy, done;
  logic             found_1, found_2, found_3, found_4;

  int passed;
  int total;
  int fails;
  int off;

  serial_max_finder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_1    (in_1),
    .in_2    (in_2),
    .in_3    (in_3),
    .in_4    (in_4),
    .busy    (busy),
    .done    (done),
    .found_1 (found_1),
    .found_2 (found_2),
    .found_3 (found_3),
    .found_4 (found_4)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] fvec();
    return {found_1, found_2, found_3, found_4};
  endfunction

  // Model of the downstream 4:2 OR-network encoder.
  function automatic logic [1:0] enc(input logic [3:0] f);
    return {f[1] | f[0], f[2] | f[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the operands and pulse start so that it is sampled at the next edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    in_1 = a; in_2 = b; in_3 = c; in_4 = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_1 = 8'hAA; in_2 = 8'hAA; in_3 = 8'hAA; in_4 = 8'hAA;
  endtask

  // Wait for done, within a bound. On cycle pulse_at, pulse start with
  // all-255-in-slot-1 operands; the design must ignore it.
  task automatic wait_done(input int pulse_at, output int offset);
    offset = 99;
    for (int i = 1; i <= 40; i++) begin
      if (i == pulse_at) begin
        start = 1'b1;
        in_1 = 8'hFF; in_2 = 8'h00; in_3 = 8'h00; in_4 = 8'h00;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        offset = i + 1;
        break;
      end
    end
  endtask

  // One full transaction: launch, latency, winner, encoder value, and the
  // cycle after done.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d, input int pulse_at,
                     input logic [3:0] exp_f, input logic [1:0] exp_enc, input int exp_off);
    launch(a, b, c, d);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(pulse_at, off);
    check({tag, "_lat"}, 32'(off), 32'(exp_off));
    check({tag, "_found"}, 32'(fvec()), 32'(exp_f));
    check({tag, "_enc"}, 32'(enc(fvec())), 32'(exp_enc));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'({done, busy}), 32'd0);
    check({tag, "_hold"}, 32'(fvec()), 32'(exp_f));
  endtask

  initial begin
    passed = 0; total = 0; fails = 0;
    rst = 1'b1; start = 1'b0;
    in_1 = 8'h00; in_2 = 8'h00; in_3 = 8'h00; in_4 = 8'h00;
    #12;
    check("reset", 32'({busy, done, fvec()}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef EARLY_EXIT_EN
    run("max2",  8'd3,   8'd200, 8'd17,  8'd199, 0, 4'b0100, 2'b01, 6);
    run("tie",   8'd50,  8'd90,  8'd90,  8'd10,  0, 4'b0100, 2'b01, 9);
    run("zero",  8'd0,   8'd0,   8'd0,   8'd0,   0, 4'b1000, 2'b00, 9);
    run("last",  8'd9,   8'd8,   8'd7,   8'd255, 0, 4'b0001, 2'b11, 2);
    run("early", 8'd128, 8'd1,   8'd2,   8'd3,   0, 4'b1000, 2'b00, 2);
    run("busyst", 8'd10, 8'd20,  8'd30,  8'd5,   2, 4'b0010, 2'b10, 6);
    run("restart", 8'd1, 8'd2,   8'd3,   8'd4,   0, 4'b0001, 2'b11, 7);
`else
    run("max2",  8'd3,   8'd200, 8'd17,  8'd199, 0, 4'b0100, 2'b01, 9);
    run("tie",   8'd50,  8'd90,  8'd90,  8'd10,  0, 4'b0100, 2'b01, 9);
    run("zero",  8'd0,   8'd0,   8'd0,   8'd0,   0, 4'b1000, 2'b00, 9);
    run("last",  8'd9,   8'd8,   8'd7,   8'd255, 0, 4'b0001, 2'b11, 9);
    run("early", 8'd128, 8'd1,   8'd2,   8'd3,   0, 4'b1000, 2'b00, 9);
    run("busyst", 8'd10, 8'd20,  8'd30,  8'd5,   2, 4'b0010, 2'b10, 9);
    run("restart", 8'd1, 8'd2,   8'd3,   8'd4,   0, 4'b0001, 2'b11, 9);
`endif

    // Reset in the middle of a scan: outputs clear at once, and no done follows.
    launch(8'd3, 8'd200, 8'd17, 8'd199);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", 32'({busy, done, fvec()}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    off = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) off++;
    end
    check("rst_nodone", 32'(off), 32'd0);

`ifdef EARLY_EXIT_EN
    run("after_rst", 8'd9, 8'd8, 8'd7, 8'd255, 0, 4'b0001, 2'b11, 2);
`else
    run("after_rst", 8'd9, 8'd8, 8'd7, 8'd255, 0, 4'b0001, 2'b11, 9);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
